imem_loader: RTL and testbench

Loads a program image into the CPU's 64-word instruction memory from a byte stream with a valid/ready handshake. It writes the instruction store that the core only reads, at the same word addressing (`PC[7:2]`).
- Bytes are packed big-endian into 32-bit words.
- Words are written to sequential imem addresses from 0.
- The core is held while loading, then released with a PC clear.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Bytes arrive big-endian and are packed four to a word.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IMEM_ADDR_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects stream bytes MSB-first into instruction words.
// Flags o_word_valid on the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clr,
    input  logic                          i_byte_valid,
    input  logic [7:0]                    i_byte,
    output logic                          o_word_valid,
    output logic [8*BYTES_PER_WORD-1:0]   o_word
);

    localparam int unsigned IDX_W   = $clog2(BYTES_PER_WORD);
    localparam int unsigned SHIFT_W = 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]   r_idx;
    logic [SHIFT_W-1:0] r_shift;

    // The completing byte bypasses the shift register so the word is ready at that edge.
    assign o_word_valid = i_byte_valid && (r_idx == LAST_IDX);
    assign o_word       = {r_shift, i_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_byte_valid) begin
            r_idx   <= r_idx + IDX_ONE;
            r_shift <= {r_shift[SHIFT_W-9:0], i_byte};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into the 64-word instruction memory while holding the core,
// then releases it with a one-cycle PC clear.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_pc_clr,
    output logic              done,
    output logic              err_len,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_hold;
    logic                r_cpu_pc_clr;
    logic                r_done;
    logic                r_err_len;
    logic [DATA_W-1:0]   r_checksum;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_word_cnt;

    logic                w_start_ok;
    logic                w_fire;
    logic                w_word_valid;
    logic [DATA_W-1:0]   w_word;
    logic [ADDR_W:0]     w_len;

    assign w_start_ok = start && (r_state != LOAD);
    assign w_fire     = in_valid && r_in_ready;
    assign w_len      = (num_words > CAP) ? CAP : num_words;

    byte_packer u_byte_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_start_ok),
        .i_byte_valid (w_fire),
        .i_byte       (in_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_hold   <= 1'b1;
            r_cpu_pc_clr <= 1'b0;
            r_done       <= 1'b0;
            r_err_len    <= 1'b0;
            r_checksum   <= '0;
            r_len        <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_mem_we     <= 1'b0;
            r_cpu_pc_clr <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_len      <= w_len;
                        r_err_len  <= (num_words > CAP);
                        r_word_cnt <= '0;
                        r_checksum <= '0;
                        if (w_len == '0) begin
                            // Nothing to load: release the core straight away.
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_cpu_hold   <= 1'b0;
                            r_cpu_pc_clr <= 1'b1;
                            r_in_ready   <= 1'b0;
                        end else begin
                            r_state    <= LOAD;
                            r_done     <= 1'b0;
                            r_cpu_hold <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_mem_wdata <= w_word;
                        r_checksum  <= r_checksum ^ w_word;
                        r_word_cnt  <= r_word_cnt + CNT_ONE;
                        if (r_word_cnt + CNT_ONE == r_len) begin
                            r_state      <= DONE;
                            r_in_ready   <= 1'b0;
                            r_done       <= 1'b1;
                            r_cpu_hold   <= 1'b0;
                            r_cpu_pc_clr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign cpu_pc_clr = r_cpu_pc_clr;
    assign done       = r_done;
    assign err_len    = r_err_len;
    assign checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs change and outputs are sampled on the falling edge.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        cpu_pc_clr;
    logic        done;
    logic        err_len;
    logic [31:0] checksum;

    int checks   = 0;
    int failures = 0;
    int we_cnt;
    int pc_cnt;
    logic [7:0]  img [256];
    logic [31:0] got_words [64];
    logic [31:0] exp_sum;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_pc_clr (cpu_pc_clr),
        .done       (done),
        .err_len    (err_len),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
    endfunction

    task automatic load_basic();
        img[0] = 8'h8C; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h04;
        img[4] = 8'hAC; img[5] = 8'h22; img[6] = 8'h00; img[7] = 8'h08;
    endtask

    task automatic do_start(input logic [6:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds img[0..nbytes-1], optionally stalling and pulsing start mid-load; checks each write.
    task automatic stream(input int nbytes, input int gap_at, input int gap_len,
                          input int start_at, input int len_words);
        int k = 0;
        int gaps = 0;
        int cyc = 0;
        int wi;
        logic hs;
        logic started = 1'b0;
        we_cnt = 0;
        pc_cnt = 0;
        while (k < nbytes && cyc < 4000) begin
            if (k == start_at && !started) begin
                start     = 1'b1;
                num_words = 7'd7;
                started   = 1'b1;
            end
            if (k == gap_at && gaps < gap_len) begin
                in_valid = 1'b0;
                gaps++;
            end else begin
                in_valid = 1'b1;
                in_byte  = img[k];
            end
            hs = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mem_we) we_cnt++;
            if (cpu_pc_clr) pc_cnt++;
            if (hs) begin
                k++;
                if (k % 4 == 0) begin
                    wi = k / 4 - 1;
                    got_words[wi] = mem_wdata;
                    check("we_latency", {31'd0, mem_we}, 32'd1);
                    check("addr", {26'd0, mem_addr}, wi);
                    check("wdata", mem_wdata, word_of(wi));
                    if (wi == len_words - 1) begin
                        check("last_ready_drop", {31'd0, in_ready}, 32'd0);
                        check("last_pc_clr", {31'd0, cpu_pc_clr}, 32'd1);
                    end
                end
            end
        end
        in_valid = 1'b0;
        check("bytes_accepted", k, nbytes);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_words = '0;
        in_valid  = 1'b0;
        in_byte   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_pc_clr", {31'd0, cpu_pc_clr}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err_len}, 32'd0);
        check("rst_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_sum", checksum, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load
        load_basic();
        do_start(7'd2);
        check("t1_ready", {31'd0, in_ready}, 32'd1);
        check("t1_hold", {31'd0, cpu_hold}, 32'd1);
        stream(8, -1, 0, -1, 2);
        check("t1_w0", got_words[0], 32'h8C010004);
        check("t1_w1", got_words[1], 32'hAC220008);
        check("t1_sum", checksum, 32'h2023000C);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_hold_rel", {31'd0, cpu_hold}, 32'd0);
        check("t1_we_cnt", we_cnt, 32'd2);
        check("t1_pc_cnt", pc_cnt, 32'd1);
        @(negedge clk);
        check("t1_pc_clr_one", {31'd0, cpu_pc_clr}, 32'd0);

        // Reload from DONE with a 3-cycle stall between bytes 2 and 3
        do_start(7'd2);
        check("t2_hold", {31'd0, cpu_hold}, 32'd1);
        check("t2_done_clr", {31'd0, done}, 32'd0);
        check("t2_sum_clr", checksum, 32'd0);
        stream(8, 2, 3, -1, 2);
        check("t2_w0", got_words[0], 32'h8C010004);
        check("t2_w1", got_words[1], 32'hAC220008);
        check("t2_sum", checksum, 32'h2023000C);
        check("t2_we_cnt", we_cnt, 32'd2);
        check("t2_done", {31'd0, done}, 32'd1);

        // Zero length
        do_start(7'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_hold", {31'd0, cpu_hold}, 32'd0);
        check("t3_we", {31'd0, mem_we}, 32'd0);
        check("t3_ready", {31'd0, in_ready}, 32'd0);
        check("t3_sum", checksum, 32'd0);

        // Overlength: clamped to 64 words
        for (int i = 0; i < 256; i++) img[i] = 8'(i);
        exp_sum = '0;
        for (int i = 0; i < 64; i++) exp_sum = exp_sum ^ word_of(i);
        do_start(7'd65);
        check("t4_err", {31'd0, err_len}, 32'd1);
        stream(256, -1, 0, -1, 64);
        check("t4_we_cnt", we_cnt, 32'd64);
        check("t4_last_addr", {26'd0, mem_addr}, 32'd63);
        check("t4_sum", checksum, exp_sum);
        check("t4_done", {31'd0, done}, 32'd1);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_ready_low", {31'd0, in_ready}, 32'd0);
            check("t4_no_we", {31'd0, mem_we}, 32'd0);
        end
        in_valid = 1'b0;
        check("t4_err_sticky", {31'd0, err_len}, 32'd1);

        // Start while LOAD is ignored
        load_basic();
        do_start(7'd2);
        check("t5_err_clr", {31'd0, err_len}, 32'd0);
        stream(8, -1, 0, 3, 2);
        check("t5_we_cnt", we_cnt, 32'd2);
        check("t5_sum", checksum, 32'h2023000C);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_err", {31'd0, err_len}, 32'd0);

        // Reset in the middle of a 3-word load
        do_start(7'd3);
        stream(6, -1, 0, -1, 3);
        check("t6_we_cnt", we_cnt, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_hold", {31'd0, cpu_hold}, 32'd1);
        check("t6_ready", {31'd0, in_ready}, 32'd0);
        check("t6_sum", checksum, 32'd0);
        check("t6_addr", {26'd0, mem_addr}, 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        do_start(7'd1);
        stream(4, -1, 0, -1, 1);
        check("t6_fresh_word", got_words[0], 32'h11223344);
        check("t6_fresh_sum", checksum, 32'h11223344);
        check("t6_fresh_done", {31'd0, done}, 32'd1);
        check("t6_we_cnt2", we_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
